muldiv_unit: RTL

- Parametrised iterative multiply/divide unit.
- Sits beside the combinational ALU in the EX stage and holds the architectural HI/LO register pair.
- Accepts one operation per start pulse and computes it over WIDTH+1 cycles, asserting busy so the hazard unit stalls.
- Also supports single-cycle moves into HI/LO and a flush from the pipeline.

---
 rtl/muldiv_unit.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative multiply/divide unit with HI/LO pair (MADD/MADDU under MULDIV_MADD_EN)
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int OPW   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [OPW-1:0]   md_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [OPW-1:0] OP_MULT  = OPW'(0);
    localparam logic [OPW-1:0] OP_MULTU = OPW'(1);
    localparam logic [OPW-1:0] OP_DIV   = OPW'(2);
    localparam logic [OPW-1:0] OP_DIVU  = OPW'(3);
    localparam logic [OPW-1:0] OP_MTHI  = OPW'(4);
    localparam logic [OPW-1:0] OP_MTLO  = OPW'(5);
    localparam logic [OPW-1:0] OP_MADD  = OPW'(6);
    localparam logic [OPW-1:0] OP_MADDU = OPW'(7);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

    state_t             state, state_nx;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   opb;
    logic [2*WIDTH-1:0] work;
    logic               op_div, neg_lo, neg_hi, dbz;

    logic               can_accept, accept, is_md, is_signed, is_div, is_madd;
    logic               sa, sb;
    logic [WIDTH-1:0]   abs_a, abs_b;

    assign can_accept = (state == S_IDLE) || (state == S_DONE);
    assign accept     = can_accept && start && !flush;

`ifdef MULDIV_MADD_EN
    logic op_madd;
    assign is_madd = (md_op == OP_MADD) || (md_op == OP_MADDU);
`else
    assign is_madd = 1'b0;
`endif

    assign is_div    = (md_op == OP_DIV) || (md_op == OP_DIVU);
    assign is_md     = (md_op == OP_MULT) || (md_op == OP_MULTU) || is_div || is_madd;
    assign is_signed = (md_op == OP_MULT) || (md_op == OP_DIV) || (md_op == OP_MADD);

    assign sa    = is_signed && a[WIDTH-1];
    assign sb    = is_signed && b[WIDTH-1];
    assign abs_a = sa ? -a : a;
    assign abs_b = sb ? -b : b;

    // Multiply step: low half holds the shifting multiplier, high half accumulates.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    assign mul_sum  = {1'b0, work[2*WIDTH-1:WIDTH]} + {1'b0, (work[0] ? opb : '0)};
    assign mul_next = {mul_sum, work[WIDTH-1:1]};

    // Restoring divide step: high half is the partial remainder, low half dividend->quotient.
    logic [WIDTH:0]     trial, diff;
    logic               ge;
    logic [WIDTH-1:0]   rem_nx;
    logic [2*WIDTH-1:0] div_next;
    assign trial    = {work[2*WIDTH-1:WIDTH], work[WIDTH-1]};
    assign diff     = trial - {1'b0, opb};
    assign ge       = trial >= {1'b0, opb};
    assign rem_nx   = ge ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
    assign div_next = {rem_nx, work[WIDTH-2:0], ge};

    logic [2*WIDTH-1:0] prod_fix, result, wr_val;
    logic [WIDTH-1:0]   q_fix, r_fix;
    assign prod_fix = neg_lo ? -work : work;
    assign q_fix    = dbz ? '1 : (neg_lo ? -work[WIDTH-1:0] : work[WIDTH-1:0]);
    assign r_fix    = neg_hi ? -work[2*WIDTH-1:WIDTH] : work[2*WIDTH-1:WIDTH];
    assign result   = op_div ? {r_fix, q_fix} : prod_fix;

`ifdef MULDIV_MADD_EN
    assign wr_val = op_madd ? ({hi, lo} + result) : result;
`else
    assign wr_val = result;
`endif

    assign busy        = (state == S_RUN) || (state == S_FIX);
    assign done        = (state == S_DONE);
    assign div_by_zero = (state == S_DONE) && dbz;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_DONE: state_nx = (accept && is_md) ? S_RUN : S_IDLE;
            S_RUN:          if (cnt == CW'(WIDTH - 1)) state_nx = S_FIX;
            S_FIX:          state_nx = S_DONE;
            default:        state_nx = S_IDLE;
        endcase
        if (flush) state_nx = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi     <= '0;
            lo     <= '0;
            cnt    <= '0;
            opb    <= '0;
            work   <= '0;
            op_div <= 1'b0;
            neg_lo <= 1'b0;
            neg_hi <= 1'b0;
            dbz    <= 1'b0;
`ifdef MULDIV_MADD_EN
            op_madd <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (accept && is_md) begin
                        work   <= {{WIDTH{1'b0}}, abs_a};
                        opb    <= abs_b;
                        cnt    <= '0;
                        op_div <= is_div;
                        neg_lo <= sa ^ sb;
                        neg_hi <= sa;
                        dbz    <= is_div && (b == '0);
`ifdef MULDIV_MADD_EN
                        op_madd <= is_madd;
`endif
                    end else if (accept && md_op == OP_MTHI) begin
                        hi <= a;
                    end else if (accept && md_op == OP_MTLO) begin
                        lo <= a;
                    end
                end
                S_RUN: begin
                    work <= op_div ? div_next : mul_next;
                    cnt  <= cnt + CW'(1);
                end
                // Results land at the FIX->DONE edge so hi/lo are valid while done is high.
                S_FIX: begin
                    if (!flush) {hi, lo} <= wr_val;
                end
                default: ;
            endcase
        end
    end
endmodule
